// File: rtl/serdesphy_i2c_slave.sv
// I2C target front-end for the SerDes PHY CSR path: decodes SCL/SDA into single-cycle
// register read/write strobes, returns read data, and drives SDA open-drain only.
module serdesphy_i2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_write_en,
  output logic       reg_read_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    WAIT
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] scl_sync_q, sda_sync_q;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wen_q, wen_d;
  logic       ren_q, ren_d;
  logic       cap1_q, cap2_q;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;

  logic scl_s, scl_h, sda_s, sda_h;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  // Bits [1:0] synchronize the pads, bit [2] holds the previous synchronized value
  assign scl_s = scl_sync_q[1];
  assign scl_h = scl_sync_q[2];
  assign sda_s = sda_sync_q[1];
  assign sda_h = sda_sync_q[2];

  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;
  assign rx_byte   = {shift_q[6:0], sda_s};

  // A START arriving with a strobe in flight kills the strobe; bus conditions release SDA at once
  assign reg_write_en = wen_q & ~start_det;
  assign reg_read_en  = ren_q & ~start_det;
  assign sda_oe       = sda_oe_q & ~start_det & ~stop_det;
  assign reg_addr     = ptr_q;
  assign reg_wdata    = wdata_q;
  assign busy         = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    rw_d     = rw_q;
    sda_oe_d = sda_oe_q;
    wen_d    = 1'b0;
    ren_d    = 1'b0;
    wdata_d  = wdata_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    ptr_d    = ptr_q;

    if (reg_write_en || cap2_q) ptr_d = ptr_q + 8'd1;
    if (cap2_q) tx_d = reg_rdata;

    if (start_det) begin
      state_d  = ADDR;
      bitcnt_d = 3'd0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d  = rx_byte;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  rw_d    = rx_byte[0];
                  ren_d   = rx_byte[0];
                  state_d = ADDR_ACK;
                end else begin
                  state_d = WAIT;
                end
              end else if (state_q == PTR) begin
                ptr_d   = rx_byte;
                state_d = PTR_ACK;
              end else begin
                wdata_d = rx_byte;
                wen_d   = 1'b1;
                state_d = WDATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          // SDA is always released on entry, so sda_oe_q tells the ACK-start fall from the ACK-end fall
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (state_q == ADDR_ACK && rw_q) begin
              sda_oe_d = ~tx_q[7];
              tx_d     = {tx_q[6:0], 1'b0};
              bitcnt_d = 3'd0;
              state_d  = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = (state_q == ADDR_ACK) ? PTR : WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_d = RACK;
          end else if (scl_fall) begin
            sda_oe_d = ~tx_q[7];
            tx_d     = {tx_q[6:0], 1'b0};
          end
        end
        RACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda_s) begin
              ren_d   = 1'b1;
              state_d = RDATA;
            end else begin
              state_d = WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      bitcnt_q   <= 3'd0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      cap1_q     <= 1'b0;
      cap2_q     <= 1'b0;
      ptr_q      <= 8'h00;
      wdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= {scl_sync_q[1:0], scl_i};
      sda_sync_q <= {sda_sync_q[1:0], sda_i};
      bitcnt_q   <= bitcnt_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
      cap1_q     <= reg_read_en;
      cap2_q     <= cap1_q;
      ptr_q      <= ptr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    tx_q    <= tx_d;
  end

endmodule
